mdio_responder: RTL and testbench

- Management-device (PHY-side) end of the MDIO link: the counterpart of mdio_transaction_generator.
- Watches mdc/mdio_out/mdio_oe from the generator and decodes Clause-22 frames addressed to its PHY address.
- Writes: issues a register-write strobe on a simple register port.
- Reads: fetches register data and serializes it back on mdio_in for the generator to capture.

---
 rtl/mdio_responder.sv | 187 ++++++++++++++++++
 tb/tb_mdio_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// PHY-side Clause-22 MDIO responder: decodes frames addressed to PHY_ADDR,
// strobes register writes/reads and serializes read data back on mdio_in.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wr_data,
  output logic        reg_wr_stb,
  output logic        reg_rd_stb,
  input  logic [15:0] reg_rd_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    RD_LAST = 3'd4,
    SKIP    = 3'd5
  } state_t;

  state_t      state;
  logic        mdc_q;
  logic        rise;
  logic        fall;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [4:0]  cur_reg;
  logic        wr_bad;
  logic        rd_load;
  logic [13:0] hdr_next;
  logic [1:0]  hdr_st;
  logic [1:0]  hdr_op;
  logic [4:0]  hdr_phy;

  assign rise     = mdc & ~mdc_q;
  assign fall     = ~mdc & mdc_q;
  // Full 14-bit header as it will look once the current bit is shifted in.
  assign hdr_next = {shreg[12:0], mdio_out};
  assign hdr_st   = hdr_next[13:12];
  assign hdr_op   = hdr_next[11:10];
  assign hdr_phy  = hdr_next[9:5];

  always_ff @(posedge clk) begin
    // mdc_q tracks mdc even in reset so a rise coincident with reset is lost.
    mdc_q <= mdc;
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      cur_reg     <= '0;
      wr_bad      <= 1'b0;
      rd_load     <= 1'b0;
      mdio_in     <= 1'b1;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_stb  <= 1'b0;
      reg_rd_stb  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_stb <= 1'b0;
      reg_rd_stb <= 1'b0;
      frame_err  <= 1'b0;
      rd_load    <= reg_rd_stb;
      if (rd_load) shreg <= reg_rd_data;

      case (state)
        IDLE: begin
          if (rise && mdio_oe && !mdio_out) begin
            state   <= HEADER;
            bit_cnt <= 5'd1;
            shreg   <= '0;
          end
        end

        HEADER: begin
          if (rise) begin
            if (!mdio_oe) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              bit_cnt   <= '0;
            end else begin
              shreg   <= {shreg[14:0], mdio_out};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd13) begin
                cur_reg <= hdr_next[4:0];
                wr_bad  <= 1'b0;
                if (hdr_st != 2'b01 || !(hdr_op == 2'b01 || hdr_op == 2'b10)) begin
                  frame_err <= 1'b1;
                  state     <= SKIP;
                end else if (hdr_phy != PHY_ADDR) begin
                  state <= SKIP;
                end else if (hdr_op == 2'b01) begin
                  state <= WRITE;
                end else begin
                  state      <= READ;
                  reg_addr   <= hdr_next[4:0];
                  reg_rd_stb <= 1'b1;
                end
              end
            end
          end
        end

        WRITE: begin
          if (rise) begin
            shreg <= {shreg[14:0], mdio_out};
            if (bit_cnt == 5'd31) begin
              state   <= IDLE;
              bit_cnt <= '0;
              if (wr_bad || !mdio_oe) begin
                frame_err <= 1'b1;
              end else begin
                reg_wr_stb  <= 1'b1;
                reg_wr_data <= {shreg[14:0], mdio_out};
                reg_addr    <= cur_reg;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              if (!mdio_oe || (bit_cnt == 5'd14 && !mdio_out) ||
                  (bit_cnt == 5'd15 && mdio_out))
                wr_bad <= 1'b1;
            end
          end
        end

        READ: begin
          if (rise) begin
            if (mdio_oe) begin
              frame_err <= 1'b1;
              mdio_in   <= 1'b1;
              state     <= IDLE;
              bit_cnt   <= '0;
            end else if (bit_cnt == 5'd31) begin
              state   <= RD_LAST;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (fall) begin
            // bit_cnt holds the index of the next bit the generator will sample.
            if (bit_cnt == 5'd14) begin
              mdio_in <= 1'b1;
            end else if (bit_cnt == 5'd15) begin
              mdio_in <= 1'b0;
            end else if (bit_cnt >= 5'd16) begin
              mdio_in <= shreg[15];
              shreg   <= {shreg[14:0], 1'b0};
            end
          end
        end

        RD_LAST: begin
          if (fall) begin
            mdio_in <= 1'b1;
            state   <= IDLE;
          end
        end

        SKIP: begin
          if (rise) begin
            if (bit_cnt == 5'd31) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          mdio_in <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder: plays the generator role on mdc/mdio
// and acts as the register file, checking against a frame-level model.
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'd1;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_stb;
  logic        reg_rd_stb;
  logic [15:0] reg_rd_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [32];
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, onehot_viol = 0;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  bit          rd_hold = 0;

  mdio_responder #(.PHY_ADDR(PHY)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .mdio_in(mdio_in), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_stb(reg_wr_stb), .reg_rd_stb(reg_rd_stb), .reg_rd_data(reg_rd_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register-file side: records strobes, returns data only in the clk after a read strobe.
  always @(negedge clk) begin
    if (reg_wr_stb === 1'b1) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wr_data; end
    if (reg_rd_stb === 1'b1) begin rd_cnt++; rd_addr = reg_addr; end
    if (frame_err === 1'b1) err_cnt++;
    if (int'(reg_wr_stb === 1'b1) + int'(reg_rd_stb === 1'b1) + int'(frame_err === 1'b1) > 1)
      onehot_viol++;
    if (reg_rd_stb === 1'b1) begin
      reg_rd_data = mem[reg_addr];
      rd_hold = 1;
    end else if (rd_hold) begin
      rd_hold = 0;
    end else begin
      reg_rd_data = 16'($urandom);
    end
  end

  task automatic drive_bit(input logic b, input logic oe, output logic cap);
    @(negedge clk);
    mdc = 1'b0; mdio_out = b; mdio_oe = oe;
    repeat (HALF) @(negedge clk);
    mdc = 1'b1;
    cap = mdio_in;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic bus_idle(input int n);
    @(negedge clk);
    mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // abort_at >= 0: generator drops mdio_oe from that frame bit onwards.
  task automatic run_frame(input string nm, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [1:0] ta,
                           input logic [15:0] data, input int abort_at, input int pre_bits);
    logic [31:0] fr, oe_v, cap, exp_cap;
    logic c;
    int w0, r0, e0, v0;
    bit hdr_ok, mine, hdr_abort, exp_wr, exp_rd, exp_err;
    fr = {st, op, phy, rg, ta, data};
    for (int i = 0; i < 32; i++)
      oe_v[31-i] = (i < 14 || op != 2'b10) && (abort_at < 0 || i < abort_at);
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; v0 = onehot_viol;
    for (int i = 0; i < pre_bits; i++) drive_bit(1'b1, 1'b1, c);
    for (int i = 0; i < 32; i++) begin
      drive_bit(fr[31-i], oe_v[31-i], c);
      cap[31-i] = c;
    end
    bus_idle(8);

    hdr_ok    = (st == 2'b01) && (op == 2'b01 || op == 2'b10);
    mine      = (phy == PHY);
    hdr_abort = (abort_at >= 1 && abort_at <= 13);
    exp_wr    = !hdr_abort && hdr_ok && mine && op == 2'b01 && ta == 2'b10 && abort_at < 0;
    exp_rd    = !hdr_abort && hdr_ok && mine && op == 2'b10;
    exp_err   = hdr_abort || !hdr_ok || (mine && op == 2'b01 && !exp_wr);
    exp_cap   = '1;
    if (exp_rd) exp_cap = {14'h3FFF, 2'b10, mem[rg]};

    checks++;
    if ((wr_cnt - w0) !== int'(exp_wr)) begin
      errors++; $display("FAIL %s wr_stb_count got %0d exp %0d", nm, wr_cnt - w0, exp_wr);
    end
    if (exp_wr) begin
      checks++;
      if (wr_addr !== rg || wr_data !== data) begin
        errors++;
        $display("FAIL %s wr_addr/data got %h/%h exp %h/%h", nm, wr_addr, wr_data, rg, data);
      end
    end
    checks++;
    if ((rd_cnt - r0) !== int'(exp_rd)) begin
      errors++; $display("FAIL %s rd_stb_count got %0d exp %0d", nm, rd_cnt - r0, exp_rd);
    end
    if (exp_rd) begin
      checks++;
      if (rd_addr !== rg) begin
        errors++; $display("FAIL %s rd_addr got %h exp %h", nm, rd_addr, rg);
      end
    end
    checks++;
    if ((err_cnt - e0) !== int'(exp_err)) begin
      errors++; $display("FAIL %s frame_err_count got %0d exp %0d", nm, err_cnt - e0, exp_err);
    end
    checks++;
    if (cap !== exp_cap) begin
      errors++; $display("FAIL %s mdio_in_bits got %h exp %h", nm, cap, exp_cap);
    end
    checks++;
    if (mdio_in !== 1'b1) begin
      errors++; $display("FAIL %s mdio_in_after got %b exp 1", nm, mdio_in);
    end
    checks++;
    if ((onehot_viol - v0) !== 0) begin
      errors++; $display("FAIL %s strobe_onehot got %0d overlaps exp 0", nm, onehot_viol - v0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mdio_in, reg_addr, reg_wr_data, reg_wr_stb, reg_rd_stb, frame_err} !==
        {1'b1, 5'd0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs got %b %h %h %b%b%b exp 1 00 0000 000",
               mdio_in, reg_addr, reg_wr_data, reg_wr_stb, reg_rd_stb, frame_err);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    run_frame("write_basic", 2'b01, 2'b01, PHY, 5'h03, 2'b10, 16'hA5C3, -1, 32);
  endtask

  task automatic test_read();
    mem[2] = 16'h1234;
    run_frame("read_basic", 2'b01, 2'b10, PHY, 5'h02, 2'b00, 16'h0000, -1, 8);
  endtask

  task automatic test_other_phy();
    run_frame("read_other_phy", 2'b01, 2'b10, 5'h07, 5'h02, 2'b00, 16'h0000, -1, 4);
    run_frame("write_other_phy", 2'b01, 2'b01, 5'h07, 5'h04, 2'b10, 16'hBEEF, -1, 4);
  endtask

  task automatic test_bad_header();
    run_frame("bad_st", 2'b00, 2'b01, PHY, 5'h05, 2'b10, 16'h1111, -1, 4);
    run_frame("after_bad_st", 2'b01, 2'b01, PHY, 5'h06, 2'b10, 16'h2222, -1, 4);
    run_frame("bad_op", 2'b01, 2'b11, PHY, 5'h07, 2'b10, 16'h3333, -1, 4);
    run_frame("after_bad_op", 2'b01, 2'b01, PHY, 5'h08, 2'b10, 16'h4444, -1, 4);
  endtask

  task automatic test_bad_ta();
    run_frame("write_ta00", 2'b01, 2'b01, PHY, 5'h0A, 2'b00, 16'h5A5A, -1, 4);
    run_frame("write_oe_drop", 2'b01, 2'b01, PHY, 5'h0B, 2'b10, 16'h6B6B, 24, 4);
    run_frame("header_abort", 2'b01, 2'b01, PHY, 5'h0C, 2'b10, 16'h7C7C, 6, 4);
  endtask

  task automatic test_reset_mid_read();
    logic c;
    int w0, e0;
    mem[9] = 16'h0000;
    w0 = wr_cnt; e0 = err_cnt;
    drive_bit(1'b1, 1'b1, c);
    for (int i = 0; i <= 20; i++) begin
      logic [31:0] fr;
      fr = {2'b01, 2'b10, PHY, 5'h09, 18'h0};
      drive_bit(fr[31-i], i < 14, c);
    end
    checks++;
    if (mdio_in !== 1'b0) begin
      errors++; $display("FAIL mid_read_driving got %b exp 0", mdio_in);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mdio_in !== 1'b1 || reg_addr !== 5'd0) begin
      errors++; $display("FAIL mid_read_reset got mdio_in=%b reg_addr=%h exp 1 00", mdio_in, reg_addr);
    end
    reset = 1'b0;
    bus_idle(6);
    checks++;
    if ((wr_cnt - w0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++; $display("FAIL mid_read_strobes got wr=%0d err=%0d exp 0 0", wr_cnt - w0, err_cnt - e0);
    end
    run_frame("write_after_reset", 2'b01, 2'b01, PHY, 5'h1F, 2'b10, 16'hC0DE, -1, 4);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_write", 2'b01, 2'b01, PHY, 5'h11, 2'b10, 16'h0F0F, -1, 0);
    run_frame("b2b_read", 2'b01, 2'b10, PHY, 5'h11, 2'b00, 16'h0000, -1, 0);
    run_frame("b2b_read2", 2'b01, 2'b10, PHY, 5'h00, 2'b00, 16'h0000, -1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [1:0] st, op, ta;
      logic [4:0] phy;
      st  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
      op  = 2'($urandom);
      phy = ($urandom_range(0, 1) == 0) ? PHY : 5'($urandom);
      ta  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      run_frame("random", st, op, phy, 5'($urandom), ta, 16'($urandom), -1,
                int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    reset = 1'b1; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    test_reset();
    test_write();
    test_read();
    test_other_phy();
    test_bad_header();
    test_bad_ta();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
